// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, parity encodings and
// the set of supported oversampling ratios.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    localparam logic ParEven = 1'b0;
    localparam logic ParOdd  = 1'b1;

    localparam logic [5:0] Prescale8  = 6'd8;
    localparam logic [5:0] Prescale16 = 6'd16;
    localparam logic [5:0] Prescale32 = 6'd32;

    // Unsupported ratios fall back to the slowest legal rate so a frame always terminates.
    function automatic logic [5:0] legal_prescale(input logic [5:0] ps);
        logic [5:0] res;
        res = Prescale32;
        if (ps == Prescale8 || ps == Prescale16 || ps == Prescale32) begin
            res = ps;
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Signal bundle between a serial-line driver/consumer and the UART receiver.
interface uart_rx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic [5:0]            PRESCALE;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/rx_data_sampler.sv
// Three-point majority vote around the centre of each serial bit.
module rx_data_sampler (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [5:0] edge_cnt_i,
    input  logic [5:0] prescale_i,
    input  logic       rx_i,
    output logic       bit_o
);
    logic [5:0] half;
    logic [2:0] samples_q, samples_d;

    always_comb begin
        half      = prescale_i >> 1;
        samples_d = samples_q;
        if (edge_cnt_i == half - 6'd1) samples_d[0] = rx_i;
        if (edge_cnt_i == half)        samples_d[1] = rx_i;
        if (edge_cnt_i == half + 6'd1) samples_d[2] = rx_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            samples_q <= '0;
        end else begin
            samples_q <= samples_d;
        end
    end

    assign bit_o = (samples_q[0] & samples_q[1]) | (samples_q[0] & samples_q[2]) |
                   (samples_q[1] & samples_q[2]);
endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/parity/stop framing with registered
// one-cycle result pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic      CLK,
    input  logic      RST,
    uart_rx_if.slave  rx_if
);
    localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

    logic                  rx_meta_q, rx_sync_q;
    rx_state_e             state_q, state_d;
    logic [5:0]            edge_cnt_q, edge_cnt_d;
    logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [5:0]            prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_bad_q, par_bad_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  sample, bit_end, start_frame;

    rx_data_sampler u_sampler (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .edge_cnt_i (edge_cnt_q),
        .prescale_i (prescale_q),
        .rx_i       (rx_sync_q),
        .bit_o      (sample)
    );

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_bad_d    = par_bad_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        start_frame  = 1'b0;
        bit_end      = (edge_cnt_q == prescale_q - 6'd1);

        if (state_q != StIdle) begin
            edge_cnt_d = bit_end ? 6'd0 : edge_cnt_q + 6'd1;
        end

        case (state_q)
            StIdle: begin
                edge_cnt_d  = 6'd0;
                start_frame = !rx_sync_q;
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = sample ? StIdle : StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d                 = shift_q >> 1;
                    shift_d[DATA_WIDTH-1]   = sample;
                    bit_cnt_d               = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LastBit) begin
                        state_d = par_en_q ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    par_bad_d = sample ^ (^shift_q) ^ (par_typ_q == ParOdd);
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d   = StIdle;
                    par_err_d = par_bad_q;
                    stp_err_d = !sample;
                    if (sample && !par_bad_q) begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end
                    // A start bit already on the line is taken now so back-to-back frames keep pace.
                    start_frame = !rx_sync_q;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start_frame) begin
            state_d    = StStart;
            edge_cnt_d = 6'd0;
            bit_cnt_d  = '0;
            par_bad_d  = 1'b0;
            prescale_d = legal_prescale(rx_if.PRESCALE);
            par_en_d   = rx_if.PAR_EN;
            par_typ_d  = rx_if.PAR_TYP;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            state_q      <= StIdle;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            prescale_q   <= Prescale8;
            par_en_q     <= 1'b0;
            par_typ_q    <= ParEven;
            par_bad_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx_if.RX_IN;
            rx_sync_q    <= rx_meta_q;
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_bad_q    <= par_bad_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign rx_if.P_DATA     = p_data_q;
    assign rx_if.data_valid = data_valid_q;
    assign rx_if.par_err    = par_err_q;
    assign rx_if.stp_err    = stp_err_q;
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bits per frame.
REQ-002 CLK  input  1  oversampling clock; all logic on rising edge.
REQ-003 RST  input  1  synchronous, active-low reset.
REQ-004 RX_IN  input  1  serial line; idle high; frame is start(0), DATA_WIDTH bits LSB first, optional parity, stop(1).
REQ-005 PRESCALE  input  6  CLK cycles per bit; legal values 8, 16, 32.
REQ-006 PAR_EN  input  1  1 = parity bit present after data.
REQ-007 PAR_TYP  input  1  0 = even, 1 = odd parity.
REQ-008 P_DATA  output  DATA_WIDTH  last correctly received data word.
REQ-009 data_valid  output  1  one-cycle pulse when P_DATA is updated.
REQ-010 par_err  output  1  one-cycle pulse on parity mismatch.
REQ-011 stp_err  output  1  one-cycle pulse when sampled stop bit is 0.

Function
REQ-012 RX_IN SHALL pass through a 2-flop synchronizer (reset value 1) before any use; all timing below refers to the synchronized line.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE -> START when the line is 0; edge counter cleared to 0 on entry to every bit state.
REQ-015 PRESCALE, PAR_EN, PAR_TYP SHALL be latched on leaving IDLE; changes mid-frame are ignored until the next frame.
REQ-016 Edge counter counts 0..PRESCALE-1 per bit; a bit ends when it reaches PRESCALE-1, where the bit counter advances and the counter wraps to 0.
REQ-017 Each bit value SHALL be the majority of samples at edge counts PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1.
REQ-018 START: if the sampled start bit is 1 (glitch), return to IDLE at bit end with no outputs asserted; else -> DATA.
REQ-019 DATA: shift sampled bits LSB first into an internal shift register; after DATA_WIDTH bits -> PARITY if latched PAR_EN = 1, else -> STOP.
REQ-020 PARITY: expected bit = XOR of received data XOR latched PAR_TYP; mismatch is recorded; -> STOP.
REQ-021 STOP: at bit end -> IDLE; in that cycle register the outputs per REQ-022..REQ-024.
REQ-022 data_valid = 1 and P_DATA = shift register iff no parity error and stop bit = 1.
REQ-023 par_err = recorded parity mismatch; stp_err = (stop bit == 0); both may pulse together.
REQ-024 On any error P_DATA SHALL hold its previous value; all pulses last exactly one cycle.
REQ-025 Back-to-back frames: a start bit immediately following a stop bit SHALL be received with no lost frame.
REQ-026 Latency: data_valid rises within PRESCALE/2+3 cycles after the stop-bit sampling centre.
REQ-027 PRESCALE outside {8,16,32}: behaviour unspecified, but the FSM SHALL always return to IDLE within one frame length of 32-cycle bits.

Reset
REQ-028 RST = 0 on a clock edge SHALL force IDLE, counters 0, shift register 0, synchronizer 1, P_DATA 0, data_valid/par_err/stp_err 0.
REQ-029 Reset mid-frame SHALL abandon the frame with no pulses; reception resumes on the next start bit after release.

Structure
REQ-030 Shared package uart_pkg SHALL hold the FSM state enum, the parity-type constants (EVEN = 0, ODD = 1) and the legal prescale constants.
REQ-031 One sub-module rx_data_sampler SHALL contain the three-sample majority vote, driven by the edge counter and PRESCALE.
REQ-032 FSM, edge/bit counters, parity check and output registers SHALL stay in uart_rx.

Verification
REQ-033 PRESCALE = 8, PAR_EN = 1, PAR_TYP = 0, frame 0xA5 with parity 0 and stop 1 -> one data_valid pulse, P_DATA = 0xA5, no errors, pulse about 88 cycles after the start edge.
REQ-034 Same frame with parity bit 1 -> par_err pulse, no data_valid, P_DATA keeps its prior value.
REQ-035 PRESCALE = 16, PAR_EN = 0, 0x5A with stop bit 0 -> stp_err pulse, no data_valid.
REQ-036 PRESCALE = 16, RX_IN low for 3 cycles then high -> no output pulses, FSM back in IDLE.
REQ-037 PRESCALE = 32, PAR_EN = 0, back-to-back 0x3C then 0xC3 -> two data_valid pulses 320 cycles apart with correct P_DATA each.
REQ-038 RST low during DATA of a frame at PRESCALE = 8, then a clean 0x81 frame -> outputs reset to 0, no pulse for the aborted frame, P_DATA = 0x81 after the second frame.
